// File: rtl/rom_ctrl.sv
// Read-address generator for a 256-word ROM: free-running stepped address,
// with two key-toggled hold modes that pin the address at word 99 or 199.
module rom_ctrl #(
  parameter logic [23:0] CNT_MAX = 24'd9_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key1,
  input  logic       key2,
  output logic [7:0] addr
);

  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  addr_cnt_q, addr_cnt_d;
  logic        key1_flag_q, key1_flag_d;
  logic        key2_flag_q, key2_flag_d;
  logic        hold;

  assign hold = key1_flag_q | key2_flag_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      addr_cnt_q  <= '0;
      key1_flag_q <= 1'b0;
      key2_flag_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      key1_flag_q <= key1_flag_d;
      key2_flag_q <= key2_flag_d;
    end
  end

  // Interval counter is cleared during hold, so each resume starts a full interval.
  always_comb begin
    cnt_d      = cnt_q;
    addr_cnt_d = addr_cnt_q;
    if (hold) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d      = '0;
      addr_cnt_d = addr_cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // key1 wins a same-cycle tie; entering one hold always cancels the other.
  always_comb begin
    key1_flag_d = key1_flag_q;
    key2_flag_d = key2_flag_q;
    if (key1) begin
      key1_flag_d = ~key1_flag_q;
      key2_flag_d = 1'b0;
    end else if (key2) begin
      key2_flag_d = ~key2_flag_q;
      key1_flag_d = 1'b0;
    end
  end

  always_comb begin
    addr = addr_cnt_q;
    if (key1_flag_q)
      addr = 8'd99;
    else if (key2_flag_q)
      addr = 8'd199;
  end

endmodule

// File: tb/tb_rom_ctrl.sv
// Randomized bench for rom_ctrl against a mode/interval reference model.
module tb_rom_ctrl;

  localparam int CNT_MAX = 99;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key1      = 1'b0;
  logic       key2      = 1'b0;
  logic [7:0] addr;

  rom_ctrl #(.CNT_MAX(24'd99)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key1     (key1),
    .key2     (key2),
    .addr     (addr)
  );

  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = free-run, 1 = hold at 99, 2 = hold at 199.
  int m_mode;
  int m_addr;
  int m_elapsed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_addr();
    if (m_mode == 1) return 99;
    if (m_mode == 2) return 199;
    return m_addr;
  endfunction

  task automatic model_reset();
    m_mode    = 0;
    m_addr    = 0;
    m_elapsed = 0;
  endtask

  task automatic step(input logic k1, input logic k2, input string tag);
    key1 = k1;
    key2 = k2;
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      if (m_mode == 0) begin
        m_elapsed++;
        if (m_elapsed == CNT_MAX + 1) begin
          m_addr    = (m_addr + 1) % 256;
          m_elapsed = 0;
        end
      end else begin
        m_elapsed = 0;
      end
      if (k1)      m_mode = (m_mode == 1) ? 0 : 1;
      else if (k2) m_mode = (m_mode == 2) ? 0 : 2;
    end
    #1;
    key1 = 1'b0;
    key2 = 1'b0;
    check(tag, {24'd0, addr}, model_addr());
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_t0", {24'd0, addr}, 0);
    step(1'b0, 1'b0, "in_reset");
    step(1'b0, 1'b0, "in_reset");
    sys_rst_n = 1'b1;

    idle(99, "first_interval");
    check("first_step_pre", {24'd0, addr}, 0);
    idle(1, "first_step");
    check("first_step_post", {24'd0, addr}, 1);
    idle(100, "second_step");
    check("second_step_post", {24'd0, addr}, 2);

    idle(256 * 100, "wrap");

    step(1'b1, 1'b0, "key1_on");
    check("key1_hold", {24'd0, addr}, 99);
    idle(1000, "key1_hold");
    step(1'b1, 1'b0, "key1_off");
    idle(300, "key1_resume");

    step(1'b0, 1'b1, "key2_on");
    check("key2_hold", {24'd0, addr}, 199);
    idle(1000, "key2_hold");
    step(1'b0, 1'b1, "key2_off");
    idle(300, "key2_resume");

    step(1'b1, 1'b0, "k1_then_k2_a");
    idle(1000, "k1_hold");
    step(1'b0, 1'b1, "k1_then_k2_b");
    check("switch_to_199", {24'd0, addr}, 199);
    idle(1000, "k2_hold");
    step(1'b0, 1'b1, "k2_exit");
    idle(200, "after_switch");

    step(1'b1, 1'b1, "both_keys");
    check("both_keys_99", {24'd0, addr}, 99);
    idle(50, "both_hold");
    step(1'b1, 1'b0, "both_exit");
    idle(200, "after_both");

    step(1'b1, 1'b0, "hold_before_rst");
    idle(20, "hold_before_rst");
    #4;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst", {24'd0, addr}, 0);
    model_reset();
    step(1'b0, 1'b0, "rst_mid_hold");
    step(1'b1, 1'b0, "rst_ignores_key");
    sys_rst_n = 1'b1;
    idle(150, "restart");

    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      step(r == 0 || r == 2, r == 1 || r == 2, "rand_key");
      idle($urandom_range(0, 150), "rand_run");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_ctrl.md
Name: rom_ctrl

Overview:
- Address generator for a 256-word single-port ROM. The ROM data output drives a display or DAC downstream.
- Free-run mode: the read address steps through 0..255, one step every CNT_MAX+1 clocks, and wraps.
- Two debounced key pulses freeze the output address at fixed words: key1 selects 99, key2 selects 199.
- A second press of the same key returns the block to free-run mode.

Parameters:
- CNT_MAX, default 24'd9_999_999: terminal count of the step-interval counter. The address steps every CNT_MAX+1 clocks, which is 200 ms at 50 MHz.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- key1  input  1  one-clock active-high pulse from an upstream debouncer; toggles hold at address 99.
- key2  input  1  one-clock active-high pulse from an upstream debouncer; toggles hold at address 199.
- addr  output  8  ROM read address.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - cnt (24-bit) = 0, addr_cnt (8-bit) = 0, key1_flag = 0, key2_flag = 0.
  - addr = 0.
- Interval counter:
  - Runs only when both flags are 0: increments each clock; at cnt==CNT_MAX it returns to 0 on the next clock.
  - Cleared to 0 on any clock where either flag is 1.
- Address counter:
  - addr_cnt increments by 1 on the clock where cnt==CNT_MAX and both flags are 0.
  - 8-bit wrap: 255 -> 0.
  - Frozen while either flag is 1, so it resumes from its held value on exit from hold.
- Flags, registered and evaluated every clock:
  - key1=1: key1_flag <= ~key1_flag; key2_flag <= 0.
  - key2=1 and key1=0: key2_flag <= ~key2_flag; key1_flag <= 0.
  - key1 and key2 both 1 in the same clock: key1 has priority and key2 is ignored.
  - Both flags are never 1 simultaneously.
- Output mux (combinational from registered state):
  - key1_flag=1: addr = 8'd99.
  - key2_flag=1: addr = 8'd199.
  - Otherwise: addr = addr_cnt.
- Latency: addr changes on the clock edge that samples the key pulse, so the new value is visible one cycle after the pulse is presented.
- Switching key1-hold to key2-hold takes one press of key2, which goes directly to 199 with no intermediate free-run.
- A pulse longer than one clock toggles once per high cycle; keys are required to be single-cycle pulses.
- Reset mid-hold: flags clear, addr = 0, and free-run restarts from 0.

Test Plan (CNT_MAX=99, 20 ns clock):
- Reset, then hold sys_rst_n=0 for 30 ns -> addr=0 throughout. After release, addr=1 after exactly 100 clocks, then +1 every 100 clocks.
- Free-run for 256×100 clocks -> addr wraps 255->0 with no glitch or skipped value.
- key1 pulse -> addr=99 from the next cycle and stays 99 for 20 µs. Second key1 pulse -> addr returns to the frozen addr_cnt value and stepping resumes with a full 100-clock interval.
- key2 pulse, then key2 pulse 20 µs later -> addr=199 between the pulses, then resumes free-run from the frozen value.
- key1 pulse, then key2 pulse 20 µs later -> addr goes 99 then 199. A further key2 pulse returns to free-run.
- Simultaneous key1 and key2 pulse from free-run -> addr=99 and key2_flag stays 0. Asserting sys_rst_n=0 during hold -> addr=0 immediately, asynchronously.
